// File: rtl/mul_m_unit.sv
// mul_m_unit: RISC-V M-extension multiply front-end (MUL, MULH, MULHSU, MULHU).
//
// Operands are reduced to unsigned magnitudes on accept. A 32-step shift-add loop then
// forms the 64-bit magnitude product. The sign is applied once at the end, and the upper
// or lower word is registered as the result.
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-low reset
//   in_vld   request valid            in_rdy  unit idle, can accept
//   funct3   00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   op1/op2  rs1/rs2 values (sampled only on the accept edge)
//   out_vld  result valid             out_rdy consumer accepts result
//   res      selected 32-bit result (held while out_vld & !out_rdy)
//   busy     high in CALC and NEG
//
// Build option: define MUL_ZERO_SKIP_EN to end the iteration early once the remaining
// multiplier bits are all zero. Results are identical either way; only latency changes.
module mul_m_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_vld,
    output logic        in_rdy,
    input  logic [1:0]  funct3,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    output logic        out_vld,
    input  logic        out_rdy,
    output logic [31:0] res,
    output logic        busy
);

    typedef enum logic [1:0] {StIdle, StCalc, StNeg, StDone} state_e;

    state_e      state_q;
    logic [1:0]  funct3_q;
    logic [63:0] acc_q;
    logic [63:0] mcd_q;
    logic [31:0] mplr_q;
    logic [31:0] res_q;
    logic [4:0]  cnt_q;
    logic        neg_q;

    logic        sign1;
    logic        sign2;
    logic [31:0] mag1;
    logic [31:0] mag2;
    logic [63:0] acc_add;
    logic [31:0] mplr_nxt;
    logic [63:0] acc_fin;
    logic        calc_last;

    // op1 is signed for MULH and MULHSU; op2 only for MULH.
    always_comb begin
        sign1    = op1[31] & ((funct3 == 2'b01) | (funct3 == 2'b10));
        sign2    = op2[31] & (funct3 == 2'b01);
        mag1     = sign1 ? (~op1 + 32'd1) : op1;
        mag2     = sign2 ? (~op2 + 32'd1) : op2;
        acc_add  = mplr_q[0] ? (acc_q + mcd_q) : acc_q;
        mplr_nxt = mplr_q >> 1;
        acc_fin  = neg_q ? (~acc_q + 64'd1) : acc_q;
`ifdef MUL_ZERO_SKIP_EN
        calc_last = (cnt_q == 5'd31) || (mplr_nxt == 32'd0);
`else
        calc_last = (cnt_q == 5'd31);
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            funct3_q <= 2'b00;
            acc_q    <= 64'd0;
            mcd_q    <= 64'd0;
            mplr_q   <= 32'd0;
            res_q    <= 32'd0;
            cnt_q    <= 5'd0;
            neg_q    <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_vld) begin
                        funct3_q <= funct3;
                        mcd_q    <= {32'd0, mag1};
                        mplr_q   <= mag2;
                        acc_q    <= 64'd0;
                        cnt_q    <= 5'd0;
                        neg_q    <= sign1 ^ sign2;
`ifdef MUL_ZERO_SKIP_EN
                        state_q  <= (mag2 == 32'd0) ? StNeg : StCalc;
`else
                        state_q  <= StCalc;
`endif
                    end
                end
                StCalc: begin
                    acc_q  <= acc_add;
                    mcd_q  <= mcd_q << 1;
                    mplr_q <= mplr_nxt;
                    cnt_q  <= cnt_q + 5'd1;
                    if (calc_last) begin
                        state_q <= StNeg;
                    end
                end
                StNeg: begin
                    acc_q   <= acc_fin;
                    res_q   <= (funct3_q == 2'b00) ? acc_fin[31:0] : acc_fin[63:32];
                    state_q <= StDone;
                end
                StDone: begin
                    if (out_rdy) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Gate with rst so the unit never advertises readiness while held in reset.
    assign in_rdy  = (state_q == StIdle) & rst;
    assign out_vld = (state_q == StDone);
    assign busy    = (state_q == StCalc) | (state_q == StNeg);
    assign res     = res_q;

endmodule

// File: tb/tb_mul_m_unit.sv
// tb_mul_m_unit: directed, table-driven bench for mul_m_unit plus hand-written
// backpressure and mid-operation reset sequences.
module tb_mul_m_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_vld;
    logic        in_rdy;
    logic [1:0]  funct3;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        out_vld;
    logic        out_rdy;
    logic [31:0] res;
    logic        busy;

    int total = 0;
    int bad   = 0;

    mul_m_unit dut (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (in_vld),
        .in_rdy  (in_rdy),
        .funct3  (funct3),
        .op1     (op1),
        .op2     (op2),
        .out_vld (out_vld),
        .out_rdy (out_rdy),
        .res     (res),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    // Expected accept-to-out_vld latency in edges.
    function automatic int exp_lat(input logic [1:0] f, input logic [31:0] b);
        logic [31:0] m;
        int          hi;
        m  = (b[31] && f == 2'b01) ? (~b + 32'd1) : b;
        hi = -1;
        for (int i = 0; i < 32; i++) begin
            if (m[i]) hi = i;
        end
`ifdef MUL_ZERO_SKIP_EN
        return (hi < 0) ? 1 : hi + 2;
`else
        return 33;
`endif
    endfunction

    // Issue one request, scramble inputs after accept, return result and latency.
    task automatic run_op(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r, output int lat);
        int w;
        int el;
        el = exp_lat(f, b);
        w  = 0;
        while (!in_rdy && w < 100) begin
            @(posedge clk);
            #1;
            w++;
        end
        chk("in_rdy_before_issue", {31'd0, in_rdy}, 32'd1);
        @(negedge clk);
        in_vld = 1'b1;
        funct3 = f;
        op1    = a;
        op2    = b;
        @(posedge clk);
        #1;
        in_vld = 1'b0;
        funct3 = 2'($urandom);
        op1    = $urandom;
        op2    = $urandom;
        chk("busy_after_accept", {31'd0, busy}, 32'd1);
        lat = 0;
        while (!out_vld && lat < 200) begin
            // A stray request mid-CALC must be ignored.
            if (lat == 5 && el > 10) begin
                in_vld = 1'b1;
            end
            if (lat == 6) begin
                in_vld = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        in_vld = 1'b0;
        r = res;
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] held;
        int          lat;
        int          stray;

        vecs[0]  = '{"mul_m1_m1",        2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
        vecs[1]  = '{"mulhu_m1_m1",      2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
        vecs[2]  = '{"mulh_m1_m1",       2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
        vecs[3]  = '{"mulh_min_min",     2'b01, 32'h80000000, 32'h80000000, 32'h40000000};
        vecs[4]  = '{"mulhsu_m1_max",    2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        vecs[5]  = '{"mul_m2_3",         2'b00, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFA};
        vecs[6]  = '{"mulh_m2_3",        2'b01, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF};
        vecs[7]  = '{"mulhu_2p31_2",     2'b11, 32'h80000000, 32'h00000002, 32'h00000001};
        vecs[8]  = '{"mulhsu_min_2p31",  2'b10, 32'h80000000, 32'h80000000, 32'hC0000000};
        vecs[9]  = '{"mulh_max_max",     2'b01, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF};
        vecs[10] = '{"mulh_min_1",       2'b01, 32'h80000000, 32'h00000001, 32'hFFFFFFFF};
        vecs[11] = '{"mulh_min_m1",      2'b01, 32'h80000000, 32'hFFFFFFFF, 32'h00000000};
        vecs[12] = '{"mulhsu_2_max",     2'b10, 32'h00000002, 32'hFFFFFFFF, 32'h00000001};
        vecs[13] = '{"mul_7_6",          2'b00, 32'h00000007, 32'h00000006, 32'h0000002A};
        vecs[14] = '{"mul_5_0",          2'b00, 32'h00000005, 32'h00000000, 32'h00000000};
        vecs[15] = '{"mul_5_3",          2'b00, 32'h00000005, 32'h00000003, 32'h0000000F};

        rst     = 1'b0;
        in_vld  = 1'b0;
        funct3  = 2'b00;
        op1     = 32'd0;
        op2     = 32'd0;
        out_rdy = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_rdy",  {31'd0, in_rdy},  32'd0);
        chk("rst_out_vld", {31'd0, out_vld}, 32'd0);
        chk("rst_busy",    {31'd0, busy},    32'd0);
        chk("rst_res",     res,              32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rel_in_rdy", {31'd0, in_rdy}, 32'd1);

        for (int i = 0; i < 16; i++) begin
            run_op(vecs[i].f, vecs[i].a, vecs[i].b, r, lat);
            chk({vecs[i].name, "_res"}, r, vecs[i].exp);
            chk({vecs[i].name, "_lat"}, 32'(lat), 32'(exp_lat(vecs[i].f, vecs[i].b)));
            @(posedge clk);
            #1;
            chk({vecs[i].name, "_rdy_after"}, {31'd0, in_rdy}, 32'd1);
            chk({vecs[i].name, "_vld_after"}, {31'd0, out_vld}, 32'd0);
        end

        // Backpressure: DONE must hold while out_rdy is low.
        @(negedge clk);
        out_rdy = 1'b0;
        run_op(2'b11, 32'h80000000, 32'h80000000, held, lat);
        chk("bp_res", held, 32'h40000000);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("bp_out_vld", {31'd0, out_vld}, 32'd1);
            chk("bp_res_hold", res, 32'h40000000);
            chk("bp_in_rdy", {31'd0, in_rdy}, 32'd0);
        end
        @(negedge clk);
        out_rdy = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_rel_in_rdy", {31'd0, in_rdy}, 32'd1);
        chk("bp_rel_out_vld", {31'd0, out_vld}, 32'd0);

        // Reset in the middle of CALC drops the operation.
        @(negedge clk);
        in_vld = 1'b1;
        funct3 = 2'b00;
        op1    = 32'h00012345;
        op2    = 32'hFFFF0003;
        @(posedge clk);
        #1;
        in_vld = 1'b0;
        repeat (14) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mrst_in_rdy",  {31'd0, in_rdy},  32'd0);
        chk("mrst_out_vld", {31'd0, out_vld}, 32'd0);
        chk("mrst_busy",    {31'd0, busy},    32'd0);
        chk("mrst_res",     res,              32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mrst_rel_in_rdy", {31'd0, in_rdy}, 32'd1);
        stray = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_vld || busy) stray++;
        end
        chk("mrst_no_output", 32'(stray), 32'd0);
        run_op(2'b00, 32'd7, 32'd6, r, lat);
        chk("mrst_mul_7_6", r, 32'h0000002A);
        chk("mrst_mul_7_6_lat", 32'(lat), 32'(exp_lat(2'b00, 32'd6)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
